// File: rtl/lii_out_arbiter.sv
// lii_out_arbiter: shares one LII phy output channel among N kernel streams.
// Round-robin arbitration picks a grant holder. The holder streams beats
// through a single output register until MAXBURST beats have been sent or
// until it runs dry. The next scan then starts just after the released holder.
//
// state    | meaning
// ST_ARB   | scanning s_tvalid circularly from rr_ptr; no beat accepted
// ST_GRANT | grant_idx owns the channel; beats flow when output can take them
module lii_out_arbiter #(
  parameter int N        = 4,
  parameter int PW       = 256,
  parameter int MAXBURST = 16
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic [N*PW-1:0]      s_tdata,
  input  logic [N-1:0]         s_tvalid,
  output logic [N-1:0]         s_tready,
  input  logic [N*8-1:0]       s_dst,
  input  logic [7:0]           cfg_src,
  output logic [PW-1:0]        lii_out_p0_tdata,
  output logic                 lii_out_p0_tvalid,
  input  logic                 lii_out_p0_tready,
  output logic [7:0]           lii_out_p0_src,
  output logic [7:0]           lii_out_p0_dst,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  // MAXBURST=1 still needs a one-bit counter; it never counts past zero.
  localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAXBURST - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_idx_q, grant_idx_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [PW-1:0]   out_data_q, out_data_d;
  logic [7:0]      out_dst_q, out_dst_d;

  logic            can_accept;
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic            g_valid;
  logic [PW-1:0]   g_data;
  logic [7:0]      g_dst;
  logic            accept;
  logic            release_grant;
  logic [IW-1:0]   next_ptr;

  // The output register can take a beat when it is empty or draining this cycle.
  assign can_accept = !out_valid_q || lii_out_p0_tready;

  // Circular scan from rr_ptr. The nearest offset wins, so offsets are walked
  // from farthest to nearest and the last match overwrites earlier ones.
  // The wrapped index is computed without modulo so non-power-of-two N works.
  always_comb begin
    logic [IW-1:0] idx;
    hit     = 1'b0;
    hit_idx = rr_ptr_q;
    idx     = rr_ptr_q;
    for (int k = N - 1; k >= 1; k--) begin
      if (rr_ptr_q >= IW'(N - k)) begin
        idx = rr_ptr_q - IW'(N - k);
      end else begin
        idx = rr_ptr_q + IW'(k);
      end
      if (s_tvalid[idx]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
    if (s_tvalid[rr_ptr_q]) begin
      hit     = 1'b1;
      hit_idx = rr_ptr_q;
    end
  end

  // Select the valid, data and destination of the current grant holder.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_dst   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx_q == IW'(i)) begin
        g_valid = s_tvalid[i];
        g_data  = s_tdata[i*PW +: PW];
        g_dst   = s_dst[i*8 +: 8];
      end
    end
  end

  // Only the holder sees ready, and only while the output register has room.
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < N; i++) begin
      s_tready[i] = (state_q == ST_GRANT) && (grant_idx_q == IW'(i)) && can_accept;
    end
  end

  assign accept = (state_q == ST_GRANT) && g_valid && can_accept;

  // A stalled output never releases: running dry only counts when a beat could
  // have moved.
  assign release_grant = (accept && (burst_cnt_q == LAST_BEAT)) ||
                         (can_accept && !g_valid);

  assign next_ptr = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IW'(1);

  // Next-state logic for the FSM, burst counter and output register.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_dst_d   = out_dst_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = g_data;
      out_dst_d   = g_dst;
    end else if (lii_out_p0_tready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_ARB: begin
        if (hit) begin
          state_d     = ST_GRANT;
          grant_idx_d = hit_idx;
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
        if (release_grant) begin
          state_d  = ST_ARB;
          rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Register all state; reset discards any held beat without draining it.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dst_q   <= out_dst_d;
    end
  end

  assign lii_out_p0_tdata  = out_data_q;
  assign lii_out_p0_tvalid = out_valid_q;
  assign lii_out_p0_dst    = out_dst_q;
  assign lii_out_p0_src    = cfg_src;
  assign grant_idx         = grant_idx_q;
  assign busy              = (state_q == ST_GRANT);

endmodule

// File: doc/lii_out_arbiter.md
LII_OUT_ARBITER -- requirements
Module: lii_out_arbiter

Interface
REQ-001 Parameter N, default 4: number of logical kernel output streams sharing one LII phy output channel; legal range 2..8.
REQ-002 Parameter PW, default 256: phy packing width in bits.
REQ-003 Parameter MAXBURST, default 16: maximum beats per grant; a power of two, legal range 1..256.
REQ-004 Port aclk  in  1: the single clock; all logic is on its rising edge.
REQ-005 Port arst  in  1: reset, synchronous, active-high.
REQ-006 Port s_tdata  in  N*PW: per-requester data; requester i occupies bits [i*PW +: PW].
REQ-007 Port s_tvalid  in  N: per-requester valid.
REQ-008 Port s_tready  out  N: per-requester ready.
REQ-009 Port s_dst  in  N*8: per-requester destination tag; requester i occupies bits [i*8 +: 8].
REQ-010 Port cfg_src  in  8: source ID of this tile; must be quasi-static.
REQ-011 Port lii_out_p0_tdata  out  PW: phy output data.
REQ-012 Port lii_out_p0_tvalid  out  1: phy output valid.
REQ-013 Port lii_out_p0_tready  in  1: phy output ready.
REQ-014 Port lii_out_p0_src  out  8: phy source tag.
REQ-015 Port lii_out_p0_dst  out  8: phy destination tag.
REQ-016 Port grant_idx  out  $clog2(N): index of the current grant holder; valid only while busy=1.
REQ-017 Port busy  out  1: high in state GRANT.

Function
REQ-018 The FSM has two states: ARB and GRANT.
REQ-019 ARB: the block selects the first i with s_tvalid[i]=1, scanning circularly from rr_ptr.
- On a hit, the next state is GRANT and grant_idx=i.
- On no hit, it stays in ARB.
- No beat is accepted in ARB, so each new grant costs one bubble cycle.
REQ-020 s_tready[i] = (state==GRANT) & (i==grant_idx) & (!lii_out_p0_tvalid | lii_out_p0_tready); all other ready bits are 0.
REQ-021 A beat is accepted when s_tvalid[i] & s_tready[i]. On acceptance, the output register loads:
- tdata from s_tdata of the granted requester;
- dst from s_dst of the granted requester;
- tvalid=1.
Latency from acceptance to lii_out_p0_tvalid is 1 cycle.
REQ-022 The output register clears tvalid when lii_out_p0_tready=1 and no new beat is accepted in the same cycle.
REQ-023 Simultaneous drain and accept in the same cycle keeps tvalid=1 with the new beat, giving full throughput of 1 beat/cycle.
REQ-024 While lii_out_p0_tvalid=1 and lii_out_p0_tready=0, tdata and dst hold stable.
REQ-025 lii_out_p0_src = cfg_src, combinational.
REQ-026 burst_cnt increments on each accepted beat and resets to 0 on every entry to GRANT.
REQ-027 Release from GRANT to ARB with rr_ptr = (grant_idx+1) mod N occurs when either condition holds:
- a beat is accepted while burst_cnt == MAXBURST-1;
- s_tvalid[grant_idx]=0 in a GRANT cycle where the output register can accept (no acceptance occurs).
REQ-028 While the output is stalled (tvalid=1 and tready=0), a deasserted s_tvalid of the grant holder does not release the grant.
REQ-029 Requesters are never starved: any continuously valid requester is granted within (N-1)*(MAXBURST+1)+1 cycles of a non-stalled output.
REQ-030 A requester must not withdraw valid while its ready is low; the block does not check this.

Reset
REQ-031 While arst=1 at a rising edge, the block enters:
- state=ARB, rr_ptr=0, burst_cnt=0, grant_idx=0;
- lii_out_p0_tvalid=0, lii_out_p0_tdata=0, lii_out_p0_dst=0;
- s_tready=0, busy=0.
REQ-032 Reset mid-burst discards any held output beat with no drain; the first post-reset grant goes to the lowest valid index ≥ 0.
REQ-033 Outputs are defined in the first cycle after arst deasserts; arbitration begins that cycle.

Verification
REQ-034 The bench shall cover the following directed scenarios:
- Single requester: stream 1 valid with 5 beats, tready=1.
  - busy rises 1 cycle after valid; 5 beats appear back-to-back with dst=s_dst[1] and src=cfg_src.
  - Grant releases, then rr_ptr=2.
- Fairness: all 4 requesters continuously valid, MAXBURST=16, tready=1.
  - Output sequence is 16 beats each from 0,1,2,3,0...
  - One idle cycle occurs between bursts.
- Backpressure: tready held 0 for 10 cycles mid-burst.
  - tdata and dst are stable throughout; no s_tready pulses.
  - burst_cnt is unchanged; the grant is held even if s_tvalid drops.
- Early release: requester 2 drops valid after 3 beats while requester 0 is valid.
  - The grant moves to requester 0 (scan from 3 wraps to 0) after the ARB cycle.
- Reset mid-burst: arst pulsed for 1 cycle during beat 7 of a burst.
  - The next cycle shows tvalid=0, busy=0, s_tready=0, and rr_ptr=0 behaviour.
- MAXBURST=1 build: all requesters valid.
  - Grants alternate each beat with an ARB bubble; each requester gets 1 beat per N*2 cycles.
